// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the exception controller: excepttype encodings, CP0 ExcCodes,
// exception vector layout and the controller FSM state encoding.
package exception_ctrl_pkg;

  localparam logic [31:0] ET_INT         = 32'h01;
  localparam logic [31:0] ET_ADEL        = 32'h04;
  localparam logic [31:0] ET_ADES        = 32'h05;
  localparam logic [31:0] ET_SYS         = 32'h08;
  localparam logic [31:0] ET_BP          = 32'h09;
  localparam logic [31:0] ET_RI          = 32'h0a;
  localparam logic [31:0] ET_CPU         = 32'h0b;
  localparam logic [31:0] ET_OV          = 32'h0c;
  localparam logic [31:0] ET_TR          = 32'h0d;
  localparam logic [31:0] ET_ERET        = 32'h0e;
  localparam logic [31:0] ET_TLBL_REFILL = 32'h10;
  localparam logic [31:0] ET_TLBL_INV    = 32'h11;
  localparam logic [31:0] ET_TLBS_REFILL = 32'h12;
  localparam logic [31:0] ET_TLBS_INV    = 32'h13;
  localparam logic [31:0] ET_MOD         = 32'h14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] VEC_BASE_BOOT  = 32'hBFC0_0200;
  localparam logic [31:0] VEC_BASE_NORM  = 32'h8000_0000;
  localparam logic [31:0] VEC_OFF_REFILL = 32'h0000_0000;
  localparam logic [31:0] VEC_OFF_GEN    = 32'h0000_0180;

  localparam int STATUS_BEV = 22;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // TLB refills only use the dedicated offset when not already at exception level.
  function automatic logic [31:0] vec_target(input logic bev, input logic exl, input logic refill);
    logic [31:0] base;
    logic [31:0] off;
    base = bev ? VEC_BASE_BOOT : VEC_BASE_NORM;
    off  = (refill && !exl) ? VEC_OFF_REFILL : VEC_OFF_GEN;
    return base + off;
  endfunction

endpackage

// File: rtl/exception_ctrl_exc_decode.sv
// Combinational decode of the memory-stage excepttype into CP0 ExcCode and
// vectoring attributes.
module exc_decode
  import exception_ctrl_pkg::*;
(
  input  logic [31:0] excepttype,
  input  logic        is_store,
  output logic        recognised,
  output logic        is_eret,
  output logic [4:0]  exccode,
  output logic        refill,
  output logic        badv_valid
);

  always_comb begin
    recognised = 1'b1;
    is_eret    = 1'b0;
    exccode    = EXC_INT;
    refill     = 1'b0;
    badv_valid = 1'b0;
    case (excepttype)
      ET_INT:  exccode = EXC_INT;
      ET_ADEL: begin exccode = EXC_ADEL; badv_valid = 1'b1; end
      ET_ADES: begin exccode = EXC_ADES; badv_valid = 1'b1; end
      ET_SYS:  exccode = EXC_SYS;
      ET_BP:   exccode = EXC_BP;
      ET_RI:   exccode = EXC_RI;
      ET_CPU:  exccode = EXC_CPU;
      ET_OV:   exccode = EXC_OV;
      ET_TR:   exccode = EXC_TR;
      ET_ERET: is_eret = 1'b1;
      ET_TLBL_REFILL: begin exccode = EXC_TLBL; refill = 1'b1; badv_valid = 1'b1; end
      ET_TLBL_INV:    begin exccode = EXC_TLBL; badv_valid = 1'b1; end
      ET_TLBS_REFILL: begin
        exccode = is_store ? EXC_TLBS : EXC_TLBL; refill = 1'b1; badv_valid = 1'b1;
      end
      ET_TLBS_INV: begin exccode = is_store ? EXC_TLBS : EXC_TLBL; badv_valid = 1'b1; end
      ET_MOD:  begin exccode = EXC_MOD; badv_valid = 1'b1; end
      default: recognised = 1'b0;
    endcase
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencing FSM: captures a memory-stage exception, waits for the data
// bus to drain, commits CP0 state with a one-cycle flush, then redirects fetch.
module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype,
  input  logic [31:0] pc_in,
  input  logic        in_delayslot,
  input  logic [31:0] badvaddr_in,
  input  logic        is_store,
  input  logic        mem_busy,
  input  logic        fetch_ack,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic        stall_pipe,
  output logic        flush,
  output logic [31:0] newpc,
  output logic        pc_valid,
  output logic        cp0_exc_we,
  output logic [4:0]  exccode,
  output logic [31:0] epc_out,
  output logic        bd_out,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_out,
  output logic        eret_we,
  output state_t      state_dbg
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, badv_q, newpc_q, newpc_d;
  logic        bd_q, eret_q, refill_q, badv_valid_q;
  logic [4:0]  exccode_q;
  logic        cap_en;

  logic        dec_recognised, dec_is_eret, dec_refill, dec_badv_valid;
  logic [4:0]  dec_exccode;
  logic        unused_status;

  assign unused_status = ^{cp0_status[31:23], cp0_status[21:2], cp0_status[0]};

  exc_decode u_decode (
    .excepttype (excepttype),
    .is_store   (is_store),
    .recognised (dec_recognised),
    .is_eret    (dec_is_eret),
    .exccode    (dec_exccode),
    .refill     (dec_refill),
    .badv_valid (dec_badv_valid)
  );

  // Handshake: pc_valid is held with newpc stable until fetch_ack is seen high on a
  // rising edge; the transfer completes on that edge and pc_valid drops next cycle.
  always_comb begin
    state_d      = state_q;
    cap_en       = 1'b0;
    stall_pipe   = 1'b0;
    flush        = 1'b0;
    pc_valid     = 1'b0;
    cp0_exc_we   = 1'b0;
    exccode      = 5'd0;
    epc_out      = 32'd0;
    bd_out       = 1'b0;
    badvaddr_we  = 1'b0;
    badvaddr_out = 32'd0;
    eret_we      = 1'b0;
    newpc_d      = eret_q ? cp0_epc
                          : vec_target(cp0_status[STATUS_BEV], cp0_status[STATUS_EXL], refill_q);
    case (state_q)
      IDLE: begin
        if (dec_recognised) begin
          cap_en  = 1'b1;
          state_d = mem_busy ? WAIT_MEM : COMMIT;
        end
      end
      WAIT_MEM: begin
        stall_pipe = 1'b1;
        if (!mem_busy) state_d = COMMIT;
      end
      COMMIT: begin
        stall_pipe = 1'b1;
        flush      = 1'b1;
        state_d    = REDIRECT;
        if (eret_q) begin
          eret_we = 1'b1;
        end else begin
          cp0_exc_we   = 1'b1;
          exccode      = exccode_q;
          epc_out      = bd_q ? (pc_q - 32'd4) : pc_q;
          bd_out       = bd_q;
          badvaddr_we  = badv_valid_q;
          badvaddr_out = badv_valid_q ? badv_q : 32'd0;
        end
      end
      REDIRECT: begin
        stall_pipe = 1'b1;
        pc_valid   = 1'b1;
        if (fetch_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= 32'd0;
      badv_q       <= 32'd0;
      newpc_q      <= 32'd0;
      bd_q         <= 1'b0;
      eret_q       <= 1'b0;
      refill_q     <= 1'b0;
      badv_valid_q <= 1'b0;
      exccode_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        pc_q         <= pc_in;
        badv_q       <= badvaddr_in;
        bd_q         <= in_delayslot;
        eret_q       <= dec_is_eret;
        refill_q     <= dec_refill;
        badv_valid_q <= dec_badv_valid;
        exccode_q    <= dec_exccode;
      end
      if (state_q == COMMIT) newpc_q <= newpc_d;
    end
  end

  assign newpc     = newpc_q;
  assign state_dbg = state_q;

endmodule
